// File: rtl/qoi_dec.sv
// qoi_dec: register-mapped QOI decoder (clk, rst, cs, we, addr, data_i in; data_o tri-state read data)
module qoi_dec (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);
  typedef enum logic [2:0] {IDLE, TAG, ARG, EMIT, DONE} state_t;
  localparam logic [31:0] PREV0 = 32'h0000_00ff;
  state_t      state_q;
  logic [31:0] px_q, prev_q, px_d, luma, diff;
  logic [31:0] idx_q [64];
  logic [29:0] tot_q, cnt_q, cnt_n;
  logic [7:0]  tag_q, dg, rd;
  logic [5:0]  hs, run_q;
  logic [2:0]  argc_q, argn;
  logic        gap_q, need, pv, busy, acc, pop, start, clr, is_arg, is_run;
  always_comb begin
    need = state_q == TAG || state_q == ARG;
    pv = state_q == EMIT && !gap_q;
    busy = need || state_q == EMIT;
    acc = cs && we && addr == 3'd0 && need;
    pop = cs && !we && addr == 3'd3 && pv;
    start = cs && we && addr == 3'd3 && data_i[7];
    clr = start && (state_q == IDLE || state_q == DONE);
    cnt_n = cnt_q + 30'd1;
    is_arg = data_i >= 8'hfe || data_i[7:6] == 2'b10;
    is_run = data_i[7:6] == 2'b11 && data_i < 8'hfe;
    diff = {prev_q[31:24] + {6'd0, data_i[5:4]} - 8'd2, prev_q[23:16] + {6'd0, data_i[3:2]} - 8'd2,
            prev_q[15:8] + {6'd0, data_i[1:0]} - 8'd2, prev_q[7:0]};
    px_d = data_i[7:6] == 2'b00 ? idx_q[data_i[5:0]] : data_i[7:6] == 2'b01 ? diff : prev_q;
    dg = {2'd0, tag_q[5:0]} - 8'd32;
    luma = {prev_q[31:24] + dg + {4'd0, data_i[7:4]} - 8'd8, prev_q[23:16] + dg,
            prev_q[15:8] + dg + {4'd0, data_i[3:0]} - 8'd8, prev_q[7:0]};
    argn = tag_q == 8'hff ? 3'd3 : tag_q == 8'hfe ? 3'd2 : 3'd0;
    hs = 6'(px_q[31:24] * 8'd3 + px_q[23:16] * 8'd5 + px_q[15:8] * 8'd7 + px_q[7:0] * 8'd11);
    rd = !addr[2] ? px_q[{~addr[1:0], 3'b000} +: 8] :
         addr == 3'd4 ? {busy, 4'd0, state_q == DONE, pv, need} :
         addr == 3'd5 ? cnt_q[7:0] : addr == 3'd6 ? cnt_q[15:8] : cnt_q[23:16];
  end
  assign data_o = cs ? rd : 8'hzz;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      px_q <= '0;
      prev_q <= PREV0;
      tot_q <= '0;
      cnt_q <= '0;
      tag_q <= '0;
      argc_q <= '0;
      run_q <= '0;
      gap_q <= 1'b0;
      for (int i = 0; i < 64; i++) idx_q[i] <= '0;
    end else begin
      if (cs && we && addr == 3'd4) tot_q[7:0] <= data_i;
      if (cs && we && addr == 3'd5) tot_q[15:8] <= data_i;
      if (cs && we && addr == 3'd6) tot_q[23:16] <= data_i;
      if (cs && we && addr == 3'd7) tot_q[29:24] <= data_i[5:0];
      if (clr) begin
        cnt_q <= '0;
        prev_q <= PREV0;
        state_q <= tot_q == '0 ? DONE : TAG;
        for (int i = 0; i < 64; i++) idx_q[i] <= '0;
      end
      if (state_q == TAG && acc) begin
        tag_q <= data_i;
        argc_q <= '0;
        px_q <= px_d;
        run_q <= is_run ? data_i[5:0] + 6'd1 : 6'd1;
        state_q <= is_arg ? ARG : EMIT;
      end
      if (state_q == ARG && acc) begin
        px_q[{~argc_q[1:0], 3'b000} +: 8] <= data_i;
        if (tag_q[7:6] == 2'b10) px_q <= luma;
        argc_q <= argc_q + 3'd1;
        if (argc_q == argn) state_q <= EMIT;
      end
      if (state_q == EMIT) begin
        gap_q <= 1'b0;
        if (pop) begin
          prev_q <= px_q;
          idx_q[hs] <= px_q;
          cnt_q <= cnt_n;
          if (run_q > 6'd1 && cnt_n != tot_q) begin
            run_q <= run_q - 6'd1;
            gap_q <= 1'b1;
          end else begin
            run_q <= '0;
            state_q <= cnt_n == tot_q ? DONE : TAG;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_qoi_dec.sv
// tb_qoi_dec: scoreboard bench for qoi_dec with directed QOI byte streams
module tb_qoi_dec;
  logic       clk = 1'b0, rst = 1'b1, cs = 1'b0, we = 1'b0, chk = 1'b0;
  logic [2:0] addr = '0;
  logic [7:0] data_i = '0;
  wire  [7:0] data_o;
  logic [7:0] exp_q[$];
  string      nm_q[$];
  int         vec = 0, miss = 0;
  qoi_dec dut (.clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .data_i(data_i), .data_o(data_o));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (chk) begin
      vec++;
      if (exp_q.size() == 0) begin
        miss++;
        $display("FAIL unexpected_read: got %02h with empty scoreboard", data_o);
      end else begin
        logic [7:0] e;
        string n;
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        if (data_o !== e) begin
          miss++;
          $display("FAIL %s: got %02h want %02h", n, data_o, e);
        end
      end
    end
  end
  task automatic rd(input logic [2:0] a, input logic [7:0] e, input string n);
    exp_q.push_back(e);
    nm_q.push_back(n);
    cs = 1'b1; we = 1'b0; addr = a; chk = 1'b1;
    @(posedge clk); #1 cs = 1'b0; chk = 1'b0;
  endtask
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; data_i = d;
    @(posedge clk); #1 cs = 1'b0; we = 1'b0;
  endtask
  task automatic put(input logic [7:0] b);
    int k;
    k = 0;
    cs = 1'b1; we = 1'b0; addr = 3'd4;
    @(negedge clk);
    while (!data_o[0] && k < 16) begin
      @(negedge clk);
      k++;
    end
    vec++;
    if (k == 16) begin
      miss++;
      $display("FAIL need_byte_timeout: need_byte stayed %0b want 1 before byte %02h", data_o[0], b);
    end
    @(posedge clk); #1;
    wr(3'd0, b);
  endtask
  task automatic setup(input int t);
    wr(3'd4, t[7:0]);
    wr(3'd5, t[15:8]);
    wr(3'd6, t[23:16]);
    wr(3'd7, t[31:24]);
    wr(3'd3, 8'h80);
  endtask
  task automatic reset();
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rd(3'd4, 8'h00, "reset_status");
    rd(3'd0, 8'h00, "reset_r");
    rd(3'd5, 8'h00, "reset_count");
    setup(1);
    put(8'hfe); put(8'h10); put(8'h20); put(8'h30);
    rd(3'd4, 8'h82, "rgb_status");
    wr(3'd0, 8'hfe);
    wr(3'd3, 8'h80);
    rd(3'd4, 8'h82, "ignored_byte_status");
    rd(3'd5, 8'h00, "ignored_byte_count");
    rd(3'd0, 8'h10, "rgb_r");
    rd(3'd1, 8'h20, "rgb_g");
    rd(3'd2, 8'h30, "rgb_b");
    rd(3'd3, 8'hff, "rgb_a_pop");
    rd(3'd4, 8'h04, "rgb_done");
    rd(3'd5, 8'h01, "rgb_count");
    wr(3'd0, 8'hfe);
    rd(3'd4, 8'h04, "done_ignores_byte");
    setup(2);
    rd(3'd4, 8'h81, "restart_status");
    rd(3'd5, 8'h00, "restart_count");
    put(8'hff); put(8'h01); put(8'h02); put(8'h03); put(8'h04);
    rd(3'd0, 8'h01, "rgba_r");
    rd(3'd3, 8'h04, "rgba_a_pop");
    put(8'h6f);
    rd(3'd0, 8'h01, "diff_r");
    rd(3'd1, 8'h03, "diff_g");
    rd(3'd2, 8'h04, "diff_b");
    rd(3'd3, 8'h04, "diff_a_pop");
    rd(3'd4, 8'h04, "diff_done");
    rd(3'd5, 8'h02, "diff_count");
    reset();
    setup(5);
    put(8'hfe); put(8'h09); put(8'h09); put(8'h09);
    rd(3'd3, 8'hff, "run_first_pop");
    put(8'hc3);
    for (int i = 0; i < 4; i++) begin
      rd(3'd4, 8'h82, "run_pv");
      rd(3'd0, 8'h09, "run_r");
      rd(3'd2, 8'h09, "run_b");
      rd(3'd3, 8'hff, "run_pop");
      rd(3'd4, i < 3 ? 8'h80 : 8'h04, "run_gap");
    end
    rd(3'd5, 8'h05, "run_count");
    reset();
    setup(2);
    put(8'hfe); put(8'hff); put(8'h00); put(8'h00);
    rd(3'd3, 8'hff, "luma_first_pop");
    put(8'ha1); put(8'h88);
    rd(3'd0, 8'h00, "luma_r_wrap");
    rd(3'd1, 8'h01, "luma_g");
    rd(3'd2, 8'h01, "luma_b");
    rd(3'd3, 8'hff, "luma_a_pop");
    reset();
    setup(3);
    put(8'hfe); put(8'h01); put(8'h02); put(8'h03);
    rd(3'd3, 8'hff, "idx_p1_pop");
    put(8'hfe); put(8'h07); put(8'h07); put(8'h07);
    rd(3'd0, 8'h07, "idx_p2_r");
    rd(3'd3, 8'hff, "idx_p2_pop");
    put(8'h17);
    rd(3'd0, 8'h01, "index_r");
    rd(3'd1, 8'h02, "index_g");
    rd(3'd2, 8'h03, "index_b");
    rd(3'd3, 8'hff, "index_a_pop");
    rd(3'd4, 8'h04, "index_done");
    reset();
    setup(2);
    put(8'hfe); put(8'h55);
    reset();
    rd(3'd4, 8'h00, "midarg_rst_status");
    rd(3'd0, 8'h00, "midarg_rst_r");
    rd(3'd3, 8'h00, "midarg_rst_a");
    rd(3'd5, 8'h00, "midarg_rst_count");
    wr(3'd3, 8'h80);
    rd(3'd4, 8'h04, "zero_total_done");
    @(posedge clk); #1;
    vec++;
    if (exp_q.size() != 0) begin
      miss++;
      $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
